hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core. Sits beside the
//  forwarding unit and covers the hazards forwarding cannot resolve:
//  - load-use stalls.
//  - taken-branch/jump flushes.
//  - multi-cycle mult/div, through a start/ready handshake with the multdiv unit.
//  Drives the hold and bubble controls of the F/D, D/X and X/M latches.
// PARAMETERS
//  MD_TIMEOUT  40  BUSY cycles before abort (used only with HAZ_MD_TIMEOUT_EN)
//  CNT_W       6   width of timeout counter; MD_TIMEOUT < 2**CNT_W
// PORTS
//  clock         in   1   core clock, rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  fd_insn       in   32  instruction in F/D latch
//  dx_insn       in   32  instruction in D/X latch
//  branch_taken  in   1   X-stage redirect (taken bne/blt, j/jal/jr/bex)
//  md_ready      in   1   multdiv result ready (data_resultRDY)
//  md_exception  in   1   multdiv exception, valid with md_ready
//  stall_fd      out  1   hold PC and F/D latch
//  stall_dx      out  1   hold D/X latch
//  flush_fd      out  1   load nop into F/D
//  bubble_dx     out  1   load nop into D/X
//  bubble_xm     out  1   load nop into X/M
//  md_ctrl_mult  out  1   1-cycle start pulse, multiply
//  md_ctrl_div   out  1   1-cycle start pulse, divide
//  md_done       out  1   X/M captures multdiv result this cycle
//  md_exc        out  1   exception for the result in X/M (valid with md_done)
// BEHAVIOUR
//  Decode fields:
//  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
//  - R-type: opcode 00000. Mul: aluop 00110. Div: aluop 00111.
//  - lw 01000, sw 00111, addi 00101, bne 00010, blt 00110, jr 00100.
//  Register $0 never creates a hazard.
//  Load-use: dx is lw, dx_rd != 0, and fd reads dx_rd, where fd reads are:
//  - rs for R/addi/lw/sw/bne/blt.
//  - rt for R-type except sll/sra.
//  - rd for bne/blt/jr.
//  - sw store data (rd) is excluded; W->M forwarding covers it.
//  Load-use response: stall_fd=1, bubble_dx=1 for exactly 1 cycle.
//  Multdiv FSM (registered state, async reset to IDLE):
//  - IDLE: dx is mul/div and branch_taken=0 -> pulse md_ctrl_mult or
//    md_ctrl_div for this cycle; assert stall_fd, stall_dx, bubble_xm; go BUSY.
//  - BUSY: hold stall_fd, stall_dx, bubble_xm at 1. md_ready=1 -> DONE, and
//    latch md_exception.
//  - DONE: md_done=1, md_exc=latched flag, stall deasserted. dx advances to
//    X/M with the result at this edge. Go IDLE.
//  Minimum mult/div occupancy is IDLE->BUSY->DONE = 3 cycles. No re-start on
//  the same instruction, because dx has changed by the next IDLE.
//  Branch: branch_taken=1 -> flush_fd=1, bubble_dx=1 in the same cycle.
//  Branch overrides the load-use stall (stall_fd=0).
//  Branch and mul/div are exclusive, since both occupy X. branch_taken is
//  ignored outside IDLE.
//  Load-use and mul/div never coincide (both sit in dx).
//  md_ready while IDLE or DONE is ignored.
//  All outputs are combinational from FSM state and inputs, with no latency
//  beyond that.
//  Reset:
//  - reset_n=0 forces every output to 0, state to IDLE, and clears the exc
//    flag and counter.
//  - Reset during BUSY aborts the operation. No md_done is issued afterwards.
// CONFIGURATION
//  HAZ_MD_TIMEOUT_EN defined:
//  - CNT_W counter clears on IDLE->BUSY and increments each BUSY cycle.
//  - Counter == MD_TIMEOUT-1 with md_ready=0 -> DONE with md_exc=1.
//  - A later md_ready for the aborted operation is ignored.
//  HAZ_MD_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for md_ready.
// TESTING
//  1. lw r5 in dx, fd add r6,r5,r7 -> stall_fd=1, bubble_dx=1 for 1 cycle,
//     then 0. lw r0 or fd sw r5 -> no stall.
//  2. mul r3,r1,r2 in dx -> md_ctrl_mult pulse at cycle 0. md_ready at cycle
//     4 -> md_done=1 at cycle 5. Stalls high cycles 0-4, low at 5.
//  3. div with md_exception=1 on md_ready -> md_exc=1 with md_done.
//     Next div without exception -> md_exc=0.
//  4. branch_taken=1 with lw-use pair present -> flush_fd=1, bubble_dx=1,
//     stall_fd=0.
//  5. reset_n low during BUSY -> all outputs 0 immediately. After release,
//     a mul in dx pulses md_ctrl_mult again.
//  6. HAZ_MD_TIMEOUT_EN, MD_TIMEOUT=40, md_ready held 0 -> md_done=1,
//     md_exc=1 on cycle 41. Late md_ready ignored.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : load-use stall, branch flush and mult/div sequencing for the
//               5-stage core. Optional macro HAZ_MD_TIMEOUT_EN adds an abort
//               after MD_TIMEOUT busy cycles.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        flush_fd,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_done,
  output logic        md_exc
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;

  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRA  = 5'b00101;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  md_state_t state;
  logic      exc_flag;

  // Field decode
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_aluop;
  logic [4:0] dx_op, dx_rd, dx_aluop;

  assign fd_op    = fd_insn[31:27];
  assign fd_rd    = fd_insn[26:22];
  assign fd_rs    = fd_insn[21:17];
  assign fd_rt    = fd_insn[16:12];
  assign fd_aluop = fd_insn[6:2];
  assign dx_op    = dx_insn[31:27];
  assign dx_rd    = dx_insn[26:22];
  assign dx_aluop = dx_insn[6:2];

  logic fd_is_r, fd_is_shift;
  logic fd_reads_rs, fd_reads_rt, fd_reads_rd;
  logic dx_is_lw, dx_is_mul, dx_is_div, dx_is_md;
  logic use_hit, load_use, md_start;

  assign fd_is_r     = (fd_op == OP_RTYPE);
  assign fd_is_shift = fd_is_r && ((fd_aluop == ALU_SLL) || (fd_aluop == ALU_SRA));

  assign fd_reads_rs = fd_is_r || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                       (fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT);
  assign fd_reads_rt = fd_is_r && !fd_is_shift;
  // sw store data (rd) is left out: W->M forwarding supplies it in time.
  assign fd_reads_rd = (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR);

  assign dx_is_lw  = (dx_op == OP_LW);
  assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_aluop == ALU_MUL);
  assign dx_is_div = (dx_op == OP_RTYPE) && (dx_aluop == ALU_DIV);
  assign dx_is_md  = dx_is_mul || dx_is_div;

  assign use_hit  = (fd_reads_rs && (fd_rs == dx_rd)) ||
                    (fd_reads_rt && (fd_rt == dx_rd)) ||
                    (fd_reads_rd && (fd_rd == dx_rd));
  assign load_use = dx_is_lw && (dx_rd != 5'd0) && use_hit;
  assign md_start = (state == MD_IDLE) && dx_is_md && !branch_taken;

`ifdef HAZ_MD_TIMEOUT_EN
  logic [CNT_W-1:0] md_cnt;
  logic             md_timeout;

  assign md_timeout = (md_cnt == CNT_W'(MD_TIMEOUT - 1));
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= MD_IDLE;
      exc_flag <= 1'b0;
`ifdef HAZ_MD_TIMEOUT_EN
      md_cnt   <= '0;
`endif
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (md_start) begin
            state <= MD_BUSY;
`ifdef HAZ_MD_TIMEOUT_EN
            md_cnt <= '0;
`endif
          end
        end
        MD_BUSY: begin
          if (md_ready) begin
            state    <= MD_DONE;
            exc_flag <= md_exception;
`ifdef HAZ_MD_TIMEOUT_EN
          end else if (md_timeout) begin
            // Abort: result slot is retired with the exception flag raised.
            state    <= MD_DONE;
            exc_flag <= 1'b1;
          end else begin
            md_cnt <= md_cnt + CNT_W'(1);
`endif
          end
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_fd     = 1'b0;
    stall_dx     = 1'b0;
    flush_fd     = 1'b0;
    bubble_dx    = 1'b0;
    bubble_xm    = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    md_done      = 1'b0;
    md_exc       = 1'b0;
    if (reset_n) begin
      unique case (state)
        MD_IDLE: begin
          // A taken branch squashes F/D and D/X, so it wins over any stall.
          if (branch_taken) begin
            flush_fd  = 1'b1;
            bubble_dx = 1'b1;
          end else if (dx_is_md) begin
            md_ctrl_mult = dx_is_mul;
            md_ctrl_div  = dx_is_div;
            stall_fd     = 1'b1;
            stall_dx     = 1'b1;
            bubble_xm    = 1'b1;
          end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end
        end
        MD_BUSY: begin
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          bubble_xm = 1'b1;
        end
        MD_DONE: begin
          md_done = 1'b1;
          md_exc  = exc_flag;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZ_MD_TIMEOUT_EN
  logic unused_bits;
  assign unused_bits = ^{fd_insn[11:7], fd_insn[1:0], dx_insn[21:7], dx_insn[1:0]};
`else
  logic [CNT_W-1:0] unused_timeout;
  logic             unused_bits;
  assign unused_timeout = CNT_W'(MD_TIMEOUT);
  assign unused_bits    = ^{fd_insn[11:7], fd_insn[1:0], dx_insn[21:7], dx_insn[1:0],
                            unused_timeout};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed and randomized checks of hazard_ctrl against a
//                  cycle-count reference model.
// Revision       : 1.0
// ============================================================================
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fd_insn = '0;
  logic [31:0] dx_insn = '0;
  logic        branch_taken = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic        stall_fd, stall_dx, flush_fd, bubble_dx, bubble_xm;
  logic        md_ctrl_mult, md_ctrl_div, md_done, md_exc;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fd_insn      (fd_insn),
    .dx_insn      (dx_insn),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .stall_fd     (stall_fd),
    .stall_dx     (stall_dx),
    .flush_fd     (flush_fd),
    .bubble_dx    (bubble_dx),
    .bubble_xm    (bubble_xm),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_done      (md_done),
    .md_exc       (md_exc)
  );

  always #5 clock = ~clock;

  // {stall_fd, stall_dx, flush_fd, bubble_dx, bubble_xm, mult, div, done, exc}
  logic [8:0] outs;
  assign outs = {stall_fd, stall_dx, flush_fd, bubble_dx, bubble_xm,
                 md_ctrl_mult, md_ctrl_div, md_done, md_exc};

  localparam logic [8:0] E_ZERO   = 9'b000000000;
  localparam logic [8:0] E_LDUSE  = 9'b100100000;
  localparam logic [8:0] E_BRANCH = 9'b001100000;
  localparam logic [8:0] E_BUSY   = 9'b110010000;
  localparam logic [31:0] NOP     = 32'd0;

  function automatic logic [31:0] r_insn(logic [4:0] aluop, logic [4:0] rd,
                                         logic [4:0] rs, logic [4:0] rt);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_insn(logic [4:0] op, logic [4:0] rd,
                                         logic [4:0] rs, logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [8:0] md_start_exp(bit is_div);
    return {5'b11001, !is_div, is_div, 2'b00};
  endfunction

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; check mid-cycle, then advance past the edge.
  task automatic step(string tag, logic [8:0] exp);
    @(negedge clock);
    chk(tag, outs, exp);
    @(posedge clock);
    #1;
  endtask

  // Reference: start cycle, lat busy cycles (ready on the last), one done cycle.
  task automatic run_md(bit is_div, int lat, bit exc);
    dx_insn = r_insn(is_div ? 5'b00111 : 5'b00110, 5'($urandom_range(1, 31)),
                     5'($urandom), 5'($urandom));
    fd_insn = $urandom;
    branch_taken = 1'b0;
    md_ready = 1'b0;
    md_exception = 1'($urandom);
    step("md_start", md_start_exp(is_div));
    for (int c = 1; c <= lat; c++) begin
      md_ready     = (c == lat);
      md_exception = (c == lat) ? exc : 1'($urandom);
      branch_taken = 1'($urandom);
      fd_insn      = $urandom;
      step("md_busy", E_BUSY);
    end
    md_ready     = 1'($urandom);
    md_exception = 1'($urandom);
    branch_taken = 1'($urandom);
    step("md_done", {7'b0000000, 1'b1, exc});
    dx_insn      = NOP;
    fd_insn      = NOP;
    branch_taken = 1'b0;
    md_ready     = 1'($urandom);
    step("md_after", E_ZERO);
    md_ready = 1'b0;
  endtask

  // Builds a random F/D instruction; the generator knows which fields it reads.
  task automatic run_lu();
    logic [4:0]  drd, rd, rs, rt;
    logic [11:0] lo;
    bit          dx_lw, hit, br;
    int          kind;
    drd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    dx_lw = ($urandom_range(0, 3) != 0);
    rd = ($urandom_range(0, 2) == 0) ? drd : 5'($urandom);
    rs = ($urandom_range(0, 2) == 0) ? drd : 5'($urandom);
    rt = ($urandom_range(0, 2) == 0) ? drd : 5'($urandom);
    lo = 12'($urandom);
    kind = $urandom_range(0, 9);
    hit = 1'b0;
    case (kind)
      0: begin
        fd_insn = r_insn(5'($urandom_range(0, 3)), rd, rs, rt);
        hit = (rs == drd) || (rt == drd);
      end
      1: begin fd_insn = r_insn(5'b00100, rd, rs, rt); hit = (rs == drd); end
      2: begin fd_insn = r_insn(5'b00101, rd, rs, rt); hit = (rs == drd); end
      3: begin fd_insn = i_insn(5'b00101, rd, rs, {rt, lo}); hit = (rs == drd); end
      4: begin fd_insn = i_insn(5'b01000, rd, rs, {rt, lo}); hit = (rs == drd); end
      5: begin fd_insn = i_insn(5'b00111, rd, rs, {rt, lo}); hit = (rs == drd); end
      6: begin
        fd_insn = i_insn(5'b00010, rd, rs, {rt, lo});
        hit = (rs == drd) || (rd == drd);
      end
      7: begin
        fd_insn = i_insn(5'b00110, rd, rs, {rt, lo});
        hit = (rs == drd) || (rd == drd);
      end
      8: begin fd_insn = {5'b00100, rd, 22'd0}; hit = (rd == drd); end
      default: begin
        fd_insn = {($urandom_range(0, 1) == 0) ? 5'b00001 : 5'b00011, rd, rs, rt, lo};
        hit = 1'b0;
      end
    endcase
    dx_insn = dx_lw ? i_insn(5'b01000, drd, 5'($urandom), 17'($urandom))
                    : i_insn(5'b00101, drd, 5'($urandom), 17'($urandom));
    br = ($urandom_range(0, 3) == 0);
    branch_taken = br;
    md_ready = 1'($urandom);
    if (br)                          step("rand_branch", E_BRANCH);
    else if (dx_lw && drd != 0 && hit) step("rand_lduse", E_LDUSE);
    else                             step("rand_nohaz", E_ZERO);
    branch_taken = 1'b0;
    md_ready = 1'b0;
  endtask

  initial begin
    // Reset state: outputs held low even with a mul sitting in D/X.
    dx_insn = r_insn(5'b00110, 5'd3, 5'd1, 5'd2);
    fd_insn = r_insn(5'b00000, 5'd6, 5'd5, 5'd7);
    branch_taken = 1'b1;
    #2;
    chk("reset_outputs", outs, E_ZERO);
    dx_insn = NOP;
    branch_taken = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Load-use basics.
    dx_insn = i_insn(5'b01000, 5'd5, 5'd1, 17'd4);
    fd_insn = r_insn(5'b00000, 5'd6, 5'd5, 5'd7);
    step("lduse_add", E_LDUSE);
    dx_insn = NOP;
    step("lduse_release", E_ZERO);
    dx_insn = i_insn(5'b01000, 5'd0, 5'd1, 17'd4);
    fd_insn = r_insn(5'b00000, 5'd6, 5'd0, 5'd0);
    step("lduse_r0", E_ZERO);
    dx_insn = i_insn(5'b01000, 5'd5, 5'd1, 17'd4);
    fd_insn = i_insn(5'b00111, 5'd5, 5'd8, 17'd0);
    step("lduse_sw_data", E_ZERO);
    fd_insn = r_insn(5'b00100, 5'd6, 5'd1, 5'd5);
    step("lduse_sll_rt", E_ZERO);
    fd_insn = {5'b00100, 5'd5, 22'd0};
    step("lduse_jr", E_LDUSE);

    // Branch overrides load-use; branch blocks a mul start.
    fd_insn = r_insn(5'b00000, 5'd6, 5'd5, 5'd7);
    branch_taken = 1'b1;
    step("branch_over_lduse", E_BRANCH);
    dx_insn = r_insn(5'b00110, 5'd3, 5'd1, 5'd2);
    step("branch_over_mul", E_BRANCH);
    branch_taken = 1'b0;
    dx_insn = NOP;
    fd_insn = NOP;
    step("branch_no_busy", E_ZERO);

    // md_ready while idle is ignored.
    md_ready = 1'b1;
    md_exception = 1'b1;
    step("ready_idle", E_ZERO);
    md_ready = 1'b0;
    md_exception = 1'b0;

    // Mult/div handshakes.
    run_md(1'b0, 4, 1'b0);
    run_md(1'b1, 2, 1'b1);
    run_md(1'b1, 3, 1'b0);
    run_md(1'b0, 1, 1'b1);

    // Reset during BUSY aborts without a later md_done.
    dx_insn = r_insn(5'b00110, 5'd3, 5'd1, 5'd2);
    step("rst_start", md_start_exp(1'b0));
    step("rst_busy", E_BUSY);
    reset_n = 1'b0;
    #1;
    chk("rst_busy_outputs", outs, E_ZERO);
    dx_insn = NOP;
    md_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_held", outs, E_ZERO);
    reset_n = 1'b1;
    step("rst_no_done", E_ZERO);
    md_ready = 1'b0;
    run_md(1'b0, 2, 1'b0);

`ifdef HAZ_MD_TIMEOUT_EN
    dx_insn = r_insn(5'b00110, 5'd3, 5'd1, 5'd2);
    step("to_start", md_start_exp(1'b0));
    for (int c = 1; c <= 40; c++) step("to_busy", E_BUSY);
    step("to_done", 9'b000000011);
    dx_insn = NOP;
    md_ready = 1'b1;
    step("to_late_ready", E_ZERO);
    step("to_late_ready2", E_ZERO);
    md_ready = 1'b0;
`endif

    // Randomized mixes.
    for (int i = 0; i < 60; i++) run_lu();
    for (int i = 0; i < 20; i++)
      run_md(1'($urandom), $urandom_range(1, 8), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
